i8080_bus_ctrl: RTL and testbench

- System-side responder for the i8080 core's native bus (addr, sync, rd, wr_n, inta_n, odata, idata, intr).
- Latches the status byte broadcast during sync.
- Decodes memory, stack, I/O and interrupt-acknowledge cycles into single-clock strobes.
- Steers read data back to the CPU.
- Contains an 8-input prioritised interrupt controller that drives intr and supplies the RST opcode during INTA.

---
 rtl/i8080_bus_ctrl.sv | 121 ++++++++++++
 tb/tb_i8080_bus_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i8080_bus_ctrl.sv
// i8080 system-side bus responder: status latch, cycle strobes, read-data steering
// and an 8-input prioritised interrupt controller that supplies RST opcodes on INTA.
module i8080_bus_ctrl #(
  parameter logic [7:0] MASK_PORT = 8'hF0,
  parameter logic [7:0] PEND_PORT = 8'hF1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_sync,
  input  logic        cpu_rd,
  input  logic        cpu_wr_n,
  input  logic        cpu_inta_n,
  input  logic [7:0]  cpu_odata,
  output logic [7:0]  cpu_idata,
  output logic        cpu_intr,
  output logic [7:0]  status,
  output logic        halted,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_port,
  input  logic [7:0]  io_rdata,
  output logic [7:0]  wdata,
  input  logic [7:0]  irq
);

  logic [7:0] status_q, mask_q, mask_d, pend_q, pend_d, vector_q, vector_d, irq_q;
  logic       halted_q, intr_q;
  logic [7:0] eff, rise, clr;
  logic [2:0] sel;
  logic       sel_vld, port_int, sync_en, wr_en, ack_en, mask_wr, pend_wr;

  assign io_port  = cpu_addr[7:0];
  assign wdata    = cpu_odata;
  assign status   = status_q;
  assign halted   = halted_q;
  assign cpu_intr = intr_q;

  assign port_int = (io_port == MASK_PORT) || (io_port == PEND_PORT);
  assign sync_en  = ~reset & ce & cpu_sync;
  assign wr_en    = ~reset & ce & ~cpu_wr_n;
  assign ack_en   = sync_en & cpu_odata[0] & cpu_odata[5];
  assign mask_wr  = wr_en & status_q[4] & (io_port == MASK_PORT);
  assign pend_wr  = wr_en & status_q[4] & (io_port == PEND_PORT);

  // Read request issued in the sync cycle so a 1-clk synchronous RAM has data by cpu_rd.
  assign mem_rd = sync_en & cpu_odata[7] & ~cpu_odata[0] & ~cpu_odata[3];
  assign mem_wr = wr_en & ~status_q[4];
  assign io_wr  = wr_en & status_q[4] & ~port_int;
  assign io_rd  = ~reset & ce & cpu_rd & status_q[6] & ~port_int;

  assign eff  = pend_q & ~mask_q;
  assign rise = irq & ~irq_q;

  // Lowest set index wins.
  always_comb begin
    sel     = 3'd0;
    sel_vld = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (eff[i]) begin
        sel     = 3'(i);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    clr      = 8'h00;
    vector_d = vector_q;
    if (ack_en) begin
      vector_d = sel_vld ? {2'b11, sel, 3'b111} : 8'hFF;
      if (sel_vld) clr[sel] = 1'b1;
    end
    if (pend_wr) clr = clr | cpu_odata;
    // New edges override any clear on the same bit.
    pend_d = (pend_q & ~clr) | rise;
    mask_d = mask_wr ? cpu_odata : mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= 8'h02;
      halted_q <= 1'b0;
      mask_q   <= 8'hFF;
      pend_q   <= 8'h00;
      vector_q <= 8'hFF;
      irq_q    <= 8'h00;
      intr_q   <= 1'b0;
    end else begin
      irq_q    <= irq;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      vector_q <= vector_d;
      intr_q   <= |eff;
      if (sync_en) begin
        status_q <= cpu_odata;
        halted_q <= cpu_odata[3];
      end
    end
  end

  always_comb begin
    cpu_idata = 8'hFF;
    if (!reset) begin
      if (!cpu_inta_n) begin
        cpu_idata = status_q[5] ? vector_q : 8'h00;
      end else if (status_q[6]) begin
        if (io_port == MASK_PORT)      cpu_idata = mask_q;
        else if (io_port == PEND_PORT) cpu_idata = pend_q;
        else                           cpu_idata = io_rdata;
      end else if (status_q[7]) begin
        cpu_idata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_i8080_bus_ctrl.sv
// Scoreboard bench for i8080_bus_ctrl: a CPU-like driver pushes expected strobes/read data,
// a negedge monitor pops and compares; interrupt state comes from a behavioural model.
module tb_i8080_bus_ctrl;

  localparam logic [2:0] KMEMRD = 3'd0;
  localparam logic [2:0] KMEMWR = 3'd1;
  localparam logic [2:0] KIORD  = 3'd2;
  localparam logic [2:0] KIOWR  = 3'd3;
  localparam logic [2:0] KRD    = 3'd4;

  logic        clk, reset, ce;
  logic [15:0] cpu_addr;
  logic        cpu_sync, cpu_rd, cpu_wr_n, cpu_inta_n;
  logic [7:0]  cpu_odata, cpu_idata;
  logic        cpu_intr;
  logic [7:0]  status;
  logic        halted, mem_rd, mem_wr, io_rd, io_wr;
  logic [7:0]  mem_rdata, io_port, io_rdata, wdata, irq;

  i8080_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .cpu_addr   (cpu_addr),
    .cpu_sync   (cpu_sync),
    .cpu_rd     (cpu_rd),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_inta_n (cpu_inta_n),
    .cpu_odata  (cpu_odata),
    .cpu_idata  (cpu_idata),
    .cpu_intr   (cpu_intr),
    .status     (status),
    .halted     (halted),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .io_port    (io_port),
    .io_rdata   (io_rdata),
    .wdata      (wdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] expq[$];

  // Reference model state
  logic [7:0] m_status, m_mask, m_pend, m_vec;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [7:0] val);
    expq.push_back({kind, val});
  endtask

  task automatic observe(input logic [2:0] kind, input logic [7:0] val);
    logic [10:0] e;
    if (expq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d value %h expected nothing", kind, val);
    end else begin
      e = expq.pop_front();
      check("event", 16'({kind, val}), 16'(e));
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd) observe(KMEMRD, 8'h00);
    if (mem_wr) observe(KMEMWR, wdata);
    if (io_rd)  observe(KIORD, io_port);
    if (io_wr)  observe(KIOWR, wdata);
    if (!reset && ce && cpu_rd) observe(KRD, cpu_idata);
  end

  function automatic logic is_int(input logic [7:0] p);
    return (p == 8'hF0) || (p == 8'hF1);
  endfunction

  task automatic model_reset();
    m_status = 8'h02;
    m_mask   = 8'hFF;
    m_pend   = 8'h00;
    m_vec    = 8'hFF;
  endtask

  // One machine cycle: sync phase, optional read or write phase, two idle clocks.
  task automatic bus_cycle(input logic [7:0] st, input logic [15:0] addr, input bit rd,
                           input bit wr, input logic [7:0] wd, input logic [7:0] ext);
    logic [7:0] port, eff, exp_rd;
    bit found;
    port = addr[7:0];
    cpu_sync  = 1'b1;
    cpu_odata = st;
    cpu_addr  = addr;
    if (st[7] && !st[0] && !st[3]) push(KMEMRD, 8'h00);
    if (st[0] && st[5]) begin
      eff   = m_pend & ~m_mask;
      m_vec = 8'hFF;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!found && eff[i]) begin
          found     = 1'b1;
          m_vec     = 8'hC7 + 8'(i * 8);
          m_pend[i] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    m_status  = st;
    cpu_sync  = 1'b0;
    cpu_odata = wd;
    check("status", 16'(status), 16'(st));
    check("halted", 16'(halted), 16'(st[3]));
    if (rd) begin
      cpu_rd     = 1'b1;
      cpu_inta_n = ~st[0];
      mem_rdata  = (st[7] && !st[6]) ? ext : ~ext;
      io_rdata   = st[6] ? ext : ~ext;
      if (st[0])                      exp_rd = st[5] ? m_vec : 8'h00;
      else if (st[6] && port == 8'hF0) exp_rd = m_mask;
      else if (st[6] && port == 8'hF1) exp_rd = m_pend;
      else if (st[6]) begin
        push(KIORD, port);
        exp_rd = ext;
      end else if (st[7])             exp_rd = ext;
      else                            exp_rd = 8'hFF;
      push(KRD, exp_rd);
    end
    if (wr) begin
      cpu_wr_n = 1'b0;
      if (!st[4])            push(KMEMWR, wd);
      else if (!is_int(port)) push(KIOWR, wd);
    end
    @(posedge clk); #1;
    if (wr && st[4] && port == 8'hF0) m_mask = wd;
    if (wr && st[4] && port == 8'hF1) m_pend = m_pend & ~wd;
    cpu_rd     = 1'b0;
    cpu_wr_n   = 1'b1;
    cpu_inta_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("intr", 16'(cpu_intr), 16'(|(m_pend & ~m_mask)));
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq = bits;
    @(posedge clk); #1;
    irq = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    m_pend = m_pend | bits;
    check("intr_after_irq", 16'(cpu_intr), 16'(|(m_pend & ~m_mask)));
  endtask

  task automatic io_out(input logic [7:0] p, input logic [7:0] d);
    bus_cycle(8'h10, {p, p}, 1'b0, 1'b1, d, 8'h00);
  endtask

  task automatic io_in(input logic [7:0] p, input logic [7:0] ext);
    bus_cycle(8'h42, {p, p}, 1'b1, 1'b0, 8'h00, ext);
  endtask

  function automatic logic [7:0] rand_port();
    case ($urandom_range(0, 3))
      0:       return 8'hF0;
      1:       return 8'hF1;
      default: return 8'($urandom_range(0, 8'hEF));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; cpu_addr = 16'h0000; cpu_sync = 1'b0; cpu_rd = 1'b0;
    cpu_wr_n = 1'b1; cpu_inta_n = 1'b1; cpu_odata = 8'h00; mem_rdata = 8'h00;
    io_rdata = 8'h00; irq = 8'h00;
    model_reset();
    #12;
    check("reset_status", 16'(status), 16'h0002);
    check("reset_halted", 16'(halted), 16'h0000);
    check("reset_intr",   16'(cpu_intr), 16'h0000);
    check("reset_idata",  16'(cpu_idata), 16'h00FF);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    io_in(8'hF0, 8'h00);
    io_in(8'hF1, 8'h00);

    // Memory read / write / stack write
    bus_cycle(8'hA2, 16'h1234, 1'b1, 1'b0, 8'h00, 8'h3E);
    bus_cycle(8'h00, 16'h2000, 1'b0, 1'b1, 8'h55, 8'h00);
    bus_cycle(8'h04, 16'hFFFE, 1'b0, 1'b1, 8'h55, 8'h00);

    // I/O, including the internal mask/pending ports
    io_out(8'hF0, 8'h0F);
    io_in(8'h10, 8'h77);
    io_in(8'hF0, 8'h00);
    io_in(8'hF1, 8'h00);

    // Priority: lowest index first
    io_out(8'hF0, 8'h00);
    pulse_irq(8'h24);
    bus_cycle(8'hA3, 16'h0100, 1'b1, 1'b0, 8'h00, 8'h00);
    io_in(8'hF1, 8'h00);
    bus_cycle(8'hA3, 16'h0100, 1'b1, 1'b0, 8'h00, 8'h00);
    bus_cycle(8'hA3, 16'h0100, 1'b1, 1'b0, 8'h00, 8'h00);

    // Masking, halt, unmask
    io_out(8'hF0, 8'hFF);
    pulse_irq(8'h01);
    io_in(8'hF1, 8'h00);
    bus_cycle(8'h8A, 16'h0200, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(8'h8A, 16'h0200, 1'b0, 1'b0, 8'h00, 8'h00);
    io_out(8'hF0, 8'hFE);
    io_out(8'hF1, 8'h01);

    // ce low: no latching, no strobes
    ce = 1'b0; cpu_sync = 1'b1; cpu_odata = 8'h82; cpu_wr_n = 1'b0;
    @(posedge clk); #1;
    check("ce_low_status", 16'(status), 16'(m_status));
    cpu_sync = 1'b0; cpu_wr_n = 1'b1; ce = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0: bus_cycle($urandom_range(0, 1) ? 8'hA2 : 8'h82, 16'($urandom), 1'b1, 1'b0,
                     8'h00, 8'($urandom));
        1: bus_cycle($urandom_range(0, 1) ? 8'h04 : 8'h00, 16'($urandom), 1'b0, 1'b1,
                     8'($urandom), 8'h00);
        2: io_in(rand_port(), 8'($urandom));
        3: io_out(rand_port(), 8'($urandom));
        4: pulse_irq(8'($urandom));
        5: bus_cycle(8'hA3, 16'($urandom), 1'b1, 1'b0, 8'h00, 8'h00);
        6: bus_cycle(8'h8A, 16'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);
        default: bus_cycle(8'h02, 16'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);
      endcase
    end

    // Reset in the middle of an INTA cycle
    io_out(8'hF0, 8'h00);
    pulse_irq(8'h18);
    cpu_sync = 1'b1; cpu_odata = 8'hA3;
    @(posedge clk); #1;
    cpu_sync = 1'b0; cpu_rd = 1'b1; cpu_inta_n = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_intr",   16'(cpu_intr), 16'h0000);
    check("rst_status", 16'(status), 16'h0002);
    check("rst_halted", 16'(halted), 16'h0000);
    check("rst_idata",  16'(cpu_idata), 16'h00FF);
    cpu_rd = 1'b0; cpu_inta_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    io_in(8'hF0, 8'h00);
    io_in(8'hF1, 8'h00);
    bus_cycle(8'hA3, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 16'(expq.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
